xmit_pkt_gen: RTL and testbench
===============================

Name: xmit_pkt_gen

Overview:
Synthesizable, parametrised packet stimulus generator for the transmit path. It drives the receive-side interface of the transmit top level: a data byte stream, a one-beat control word and a priority flag. Packet order is a configurable pattern of N low-priority packets followed by 1 high-priority packet, repeated for a programmable loop count. It has per-class packet lengths, inter-packet gaps and downstream backpressure. It replaces open-loop timed stimulus in benches and on-board self-test.

Parameters:
DATA_W, 8, data byte width
LEN_W, 12, packet length field width; control word is {len, len}, 2*LEN_W bits
CNT_W, 16, width of loop and packet counters
LO_SEED, 0, first data seed for low-priority packets
HI_SEED, 240, first data seed for high-priority packets

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches cfg_* and begins generation (ignored when busy=1)
stop  in  1  one-cycle pulse; finish the current packet, then return to IDLE
ready  in  1  downstream accept; a beat transfers on a cycle with valid=1 and ready=1
cfg_len_lo  in  LEN_W  low-priority packet length in beats
cfg_len_hi  in  LEN_W  high-priority packet length in beats
cfg_num_lo  in  8  low-priority packets per loop
cfg_num_loops  in  CNT_W  loops to run; 0 = run until stop
cfg_gap  in  8  idle cycles between packets
f_data_in  out  DATA_W  data beat
f_rec_data_valid  out  1  data beat valid
f_ctrl_in  out  2*LEN_W  control word {len, len}; zero when not valid
f_rec_frame_valid  out  1  control valid, first beat of packet only
f_hi_priority  out  1  1 = current packet is high priority; held for the whole packet
busy  out  1  generator active (not IDLE)
done  out  1  one-cycle pulse at normal completion or after stop
pkt_count  out  CNT_W  packets completed since start; wraps

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; seeds reload to LO_SEED and HI_SEED; counters 0.
- States:
  - IDLE -> FIRST on start.
  - FIRST: first beat. data_valid=1, frame_valid=1, ctrl={len,len}. On transfer -> DATA, or -> END_PKT if len=1.
  - DATA: beats 2..len. Last transfer -> END_PKT.
  - END_PKT: one cycle. Update counters. -> GAP if cfg_gap>0, else FIRST of the next packet, or DONE.
  - GAP: cfg_gap cycles with valid=0, then -> FIRST.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- The END_PKT cycle is always present, so the minimum inter-packet spacing is one idle cycle.
- Backpressure: while ready=0, all outputs hold stable and the beat counter freezes. valid never deasserts mid-packet while ready=0.
- Order within a loop: cfg_num_lo low packets, then 1 high packet.
  - cfg_num_lo=0 gives high-priority packets only.
  - The loop counter increments after each high packet.
  - The generator ends when loops == cfg_num_loops and cfg_num_loops != 0.
- Length 0 is treated as 1.
- Data: each packet's seed is its class seed. The class seed increments by 1 mod 2^DATA_W after each packet of that class.
- Config latch: cfg_* is latched at start; later changes have no effect until the next start.
- stop:
  - Mid-packet: the packet completes, including its backpressure stalls, then -> DONE.
  - In GAP: -> DONE immediately.
  - stop and start in the same cycle while in IDLE: start wins.
- pkt_count increments in END_PKT and clears on start.
- Reset mid-packet: outputs drop to 0 at once; no partial-packet recovery.

Optional Feature:
PKT_GEN_INCR_DATA_EN:
- Defined: f_data_in = seed + beat_index mod 2^DATA_W, where beat_index is 0 on the FIRST beat.
- Undefined: f_data_in = seed, constant for every beat of the packet.
- Control, priority and timing are identical in both builds.

Test Plan:
- Basic pattern. len_lo=64, len_hi=512, num_lo=10, loops=1, gap=0, ready=1 -> 11 packets.
  - First 10 low: ctrl=24'h040040, hi_priority=0, seeds 0..9.
  - Last high: ctrl=24'h200200, hi_priority=1, seed 240.
  - pkt_count=11, done pulses once.
- Backpressure. len=8, ready toggled 1/0 every cycle -> exactly 8 transfers per packet. Outputs stable on every ready=0 cycle. frame_valid high only while the first beat is pending.
- Gap and boundaries.
  - gap=3 -> exactly 4 idle cycles (END_PKT + 3 gap) between last beat and next frame_valid.
  - len=1 -> frame_valid and data_valid together for one transfer.
  - len=0 behaves as len=1.
- Seed wrap. HI_SEED=255, num_lo=0, loops=3 -> high seeds 255, 0, 1. With PKT_GEN_INCR_DATA_EN and len=4, first packet data is 255, 0, 1, 2.
- Stop and reset.
  - loops=0, stop in beat 5 of a 64-beat packet -> packet completes (64 transfers), done pulses, busy=0.
  - reset asserted mid-packet -> all outputs 0 immediately.
- Config latch. Change cfg_len_lo from 64 to 16 while busy -> packets keep ctrl=24'h040040 until the next start.

Source files
------------

// File: rtl/xmit_pkt_gen.sv
// Packet stimulus generator: N low-priority packets then one high-priority packet per loop.
// Define PKT_GEN_INCR_DATA_EN for incrementing payload bytes (seed + beat); default is constant seed.
module xmit_pkt_gen #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned LO_SEED = 0,
  parameter int unsigned HI_SEED = 240
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 ready,
  input  logic [LEN_W-1:0]     cfg_len_lo,
  input  logic [LEN_W-1:0]     cfg_len_hi,
  input  logic [7:0]           cfg_num_lo,
  input  logic [CNT_W-1:0]     cfg_num_loops,
  input  logic [7:0]           cfg_gap,
  output logic [DATA_W-1:0]    f_data_in,
  output logic                 f_rec_data_valid,
  output logic [2*LEN_W-1:0]   f_ctrl_in,
  output logic                 f_rec_frame_valid,
  output logic                 f_hi_priority,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pkt_count
);

  typedef enum logic [2:0] {StIdle, StFirst, StData, StEndPkt, StGap, StDone} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_lo_q, len_lo_d, len_hi_q, len_hi_d;
  logic [7:0]         num_lo_q, num_lo_d, gap_q, gap_d;
  logic [CNT_W-1:0]   num_loops_q, num_loops_d;
  logic [DATA_W-1:0]  lo_seed_q, lo_seed_d, hi_seed_q, hi_seed_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [7:0]         lo_idx_q, lo_idx_d, gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   loops_q, loops_d, pkt_count_q, pkt_count_d;
  logic               hi_q, hi_d, stop_q, stop_d;

  logic [LEN_W-1:0]   len_cur, len_eff;
  logic [DATA_W-1:0]  seed_cur;
  logic               valid, load, last_loop;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      len_lo_q    <= '0;
      len_hi_q    <= '0;
      num_lo_q    <= '0;
      gap_q       <= '0;
      num_loops_q <= '0;
      lo_seed_q   <= DATA_W'(LO_SEED);
      hi_seed_q   <= DATA_W'(HI_SEED);
      beat_q      <= '0;
      lo_idx_q    <= '0;
      gap_cnt_q   <= '0;
      loops_q     <= '0;
      pkt_count_q <= '0;
      hi_q        <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_hi_q    <= len_hi_d;
      num_lo_q    <= num_lo_d;
      gap_q       <= gap_d;
      num_loops_q <= num_loops_d;
      lo_seed_q   <= lo_seed_d;
      hi_seed_q   <= hi_seed_d;
      beat_q      <= beat_d;
      lo_idx_q    <= lo_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      loops_q     <= loops_d;
      pkt_count_q <= pkt_count_d;
      hi_q        <= hi_d;
      stop_q      <= stop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_hi_d    = len_hi_q;
    num_lo_d    = num_lo_q;
    gap_d       = gap_q;
    num_loops_d = num_loops_q;
    lo_seed_d   = lo_seed_q;
    hi_seed_d   = hi_seed_q;
    beat_d      = beat_q;
    lo_idx_d    = lo_idx_q;
    gap_cnt_d   = gap_cnt_q;
    loops_d     = loops_q;
    pkt_count_d = pkt_count_q;
    hi_d        = hi_q;
    stop_d      = stop_q;
    last_loop   = 1'b0;

    len_cur = hi_q ? len_hi_q : len_lo_q;
    len_eff = (len_cur == '0) ? LEN_W'(1) : len_cur;
    load    = start && ((state_q == StIdle) || (state_q == StDone));

    unique case (state_q)
      StIdle, StDone: begin
        stop_d  = 1'b0;
        state_d = StIdle;
        // start outranks a simultaneous stop: stop is not captured here
        if (load) begin
          len_lo_d    = cfg_len_lo;
          len_hi_d    = cfg_len_hi;
          num_lo_d    = cfg_num_lo;
          gap_d       = cfg_gap;
          num_loops_d = cfg_num_loops;
          hi_d        = (cfg_num_lo == 8'd0);
          lo_idx_d    = '0;
          loops_d     = '0;
          pkt_count_d = '0;
          beat_d      = '0;
          state_d     = StFirst;
        end
      end
      StFirst: begin
        stop_d = stop_q | stop;
        if (ready) begin
          if (len_eff == LEN_W'(1)) begin
            state_d = StEndPkt;
          end else begin
            beat_d  = LEN_W'(1);
            state_d = StData;
          end
        end
      end
      StData: begin
        stop_d = stop_q | stop;
        if (ready) begin
          if (beat_q == len_eff - LEN_W'(1)) state_d = StEndPkt;
          else                               beat_d  = beat_q + LEN_W'(1);
        end
      end
      StEndPkt: begin
        pkt_count_d = pkt_count_q + CNT_W'(1);
        beat_d      = '0;
        if (hi_q) begin
          hi_seed_d = hi_seed_q + DATA_W'(1);
          loops_d   = loops_q + CNT_W'(1);
          lo_idx_d  = '0;
          hi_d      = (num_lo_q == 8'd0);
          last_loop = (num_loops_q != '0) && (loops_d == num_loops_q);
        end else begin
          lo_seed_d = lo_seed_q + DATA_W'(1);
          lo_idx_d  = lo_idx_q + 8'd1;
          hi_d      = (lo_idx_d == num_lo_q);
        end
        if (last_loop || stop_q || stop) begin
          state_d = StDone;
        end else if (gap_q != 8'd0) begin
          gap_cnt_d = gap_q;
          state_d   = StGap;
        end else begin
          state_d = StFirst;
        end
      end
      StGap: begin
        if (stop_q || stop)           state_d   = StDone;
        else if (gap_cnt_q <= 8'd1)   state_d   = StFirst;
        else                          gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid    = (state_q == StFirst) || (state_q == StData);
    seed_cur = hi_q ? hi_seed_q : lo_seed_q;
`ifdef PKT_GEN_INCR_DATA_EN
    f_data_in = valid ? (seed_cur + DATA_W'(beat_q)) : '0;
`else
    f_data_in = valid ? seed_cur : '0;
`endif
    f_rec_data_valid  = valid;
    f_rec_frame_valid = (state_q == StFirst);
    f_ctrl_in         = (state_q == StFirst) ? {len_eff, len_eff} : '0;
    f_hi_priority     = valid & hi_q;
    busy              = (state_q != StIdle) && (state_q != StDone);
    done              = (state_q == StDone);
    pkt_count         = pkt_count_q;
  end

endmodule

// File: tb/tb_xmit_pkt_gen.sv
// Self-checking bench for xmit_pkt_gen: a packet-list model drives a per-cycle output compare.
module tb_xmit_pkt_gen;
  localparam int unsigned LO_S = 0;
  localparam int unsigned HI_S = 240;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, ready = 1'b1;
  logic [11:0] cfg_len_lo = '0, cfg_len_hi = '0;
  logic [7:0]  cfg_num_lo = '0, cfg_gap = '0;
  logic [15:0] cfg_num_loops = '0;
  logic [7:0]  f_data_in;
  logic        f_rec_data_valid, f_rec_frame_valid, f_hi_priority, busy, done;
  logic [23:0] f_ctrl_in;
  logic [15:0] pkt_count;

  xmit_pkt_gen #(
    .DATA_W(8), .LEN_W(12), .CNT_W(16), .LO_SEED(LO_S), .HI_SEED(HI_S)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .stop(stop), .ready(ready),
    .cfg_len_lo(cfg_len_lo), .cfg_len_hi(cfg_len_hi), .cfg_num_lo(cfg_num_lo),
    .cfg_num_loops(cfg_num_loops), .cfg_gap(cfg_gap), .f_data_in(f_data_in),
    .f_rec_data_valid(f_rec_data_valid), .f_ctrl_in(f_ctrl_in),
    .f_rec_frame_valid(f_rec_frame_valid), .f_hi_priority(f_hi_priority), .busy(busy),
    .done(done), .pkt_count(pkt_count)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Model: the expected packet list for a run, consumed beat by beat
  typedef struct {
    logic        hi;
    int unsigned len;
    logic [7:0]  seed;
  } pkt_t;

  pkt_t        exp_q[$];
  pkt_t        mp;
  int          mbeat = 0;
  logic [7:0]  mseed_lo, mseed_hi, ed;
  logic [11:0] l12;
  int          exp_gap = 0, idle_cnt = 0, done_cnt = 0;
  bit          have_prev = 0, mon_en = 0, rmode = 0, stall_prev = 0, first_seen = 0;
  logic [33:0] snap;
  logic [23:0] first_ctrl, last_ctrl;
  logic [7:0]  first_data, last_data;
  logic        last_hi;

  function automatic int unsigned eff(input int unsigned l);
    return (l == 0) ? 1 : l;
  endfunction

  always @(posedge clk_sys) begin
    #1;
    ready = rmode ? ~ready : 1'b1;
  end

  always @(negedge clk_sys) begin
    if (reset && mon_en) begin
      if (f_rec_data_valid) begin
        if (stall_prev)
          chk("stall_hold", {f_data_in, f_ctrl_in, f_hi_priority, f_rec_frame_valid}, snap);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
          stall_prev = 1'b0;
        end else begin
          mp  = exp_q[0];
          l12 = mp.len[11:0];
          ed  = mp.seed;
`ifdef PKT_GEN_INCR_DATA_EN
          ed = mp.seed + 8'(mbeat);
`endif
          chk("frame_valid", f_rec_frame_valid, mbeat == 0);
          chk("ctrl", f_ctrl_in, (mbeat == 0) ? {l12, l12} : 24'h0);
          chk("hi_priority", f_hi_priority, mp.hi);
          chk("data", f_data_in, ed);
          chk("busy_in_pkt", busy, 1);
          if (mbeat == 0) begin
            if (have_prev) chk("idle_gap", idle_cnt, exp_gap + 1);
            if (!first_seen) begin
              first_ctrl = f_ctrl_in;
              first_data = f_data_in;
              first_seen = 1'b1;
            end
            last_ctrl = f_ctrl_in;
            last_data = f_data_in;
            last_hi   = f_hi_priority;
          end
          stall_prev = !ready;
          snap = {f_data_in, f_ctrl_in, f_hi_priority, f_rec_frame_valid};
          if (ready) begin
            mbeat++;
            if (mbeat == int'(mp.len)) begin
              exp_q.delete(0);
              mbeat     = 0;
              have_prev = 1'b1;
              idle_cnt  = 0;
            end
          end
        end
      end else begin
        if (stall_prev) chk("stall_valid", f_rec_data_valid, 1);
        stall_prev = 1'b0;
        idle_cnt++;
        chk("idle_frame_valid", f_rec_frame_valid, 0);
        chk("idle_ctrl", f_ctrl_in, 0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    rmode  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_data", f_data_in, 0);
    chk("rst_dvalid", f_rec_data_valid, 0);
    chk("rst_ctrl", f_ctrl_in, 0);
    chk("rst_fvalid", f_rec_frame_valid, 0);
    chk("rst_hi", f_hi_priority, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkt_count", pkt_count, 0);
    exp_q.delete();
    mbeat      = 0;
    mseed_lo   = 8'(LO_S);
    mseed_hi   = 8'(HI_S);
    stall_prev = 1'b0;
    first_seen = 1'b0;
    @(posedge clk_sys);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic run(input int unsigned lenlo, input int unsigned lenhi, input int unsigned numlo,
                     input int unsigned loops, input int unsigned gap, input bit tog,
                     input bit with_stop);
    cfg_len_lo    = 12'(lenlo);
    cfg_len_hi    = 12'(lenhi);
    cfg_num_lo    = 8'(numlo);
    cfg_num_loops = 16'(loops);
    cfg_gap       = 8'(gap);
    rmode         = tog;
    exp_gap       = int'(gap);
    have_prev     = 1'b0;
    done_cnt      = 0;
    for (int l = 0; l < int'(loops); l++) begin
      for (int i = 0; i < int'(numlo); i++) begin
        exp_q.push_back('{1'b0, eff(lenlo), mseed_lo});
        mseed_lo++;
      end
      exp_q.push_back('{1'b1, eff(lenhi), mseed_hi});
      mseed_hi++;
    end
    if (loops == 0) begin
      exp_q.push_back('{1'b0, eff(lenlo), mseed_lo});
      mseed_lo++;
    end
    @(posedge clk_sys);
    #1;
    start = 1'b1;
    stop  = with_stop;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int exp_pkts);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk_sys);
    if (done_cnt == 0) fail_now("done_timeout");
    repeat (3) @(posedge clk_sys);
    #2;
    chk("done_pulses", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("pkt_count", pkt_count, exp_pkts);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #3;
    do_reset();

    // Basic pattern: 10 low + 1 high
    run(64, 512, 10, 1, 0, 1'b0, 1'b0);
    wait_done(3000, 11);
    chk("basic_first_ctrl", first_ctrl, 24'h040040);
    chk("basic_first_seed", first_data, 8'h00);
    chk("basic_last_ctrl", last_ctrl, 24'h200200);
    chk("basic_last_hi", last_hi, 1'b1);
    chk("basic_last_seed", last_data, 8'hF0);

    // Backpressure: ready toggles every cycle
    do_reset();
    run(8, 8, 2, 2, 0, 1'b1, 1'b0);
    wait_done(1000, 6);

    // Gap of 3; stop together with start from IDLE must be ignored
    do_reset();
    run(4, 4, 1, 2, 3, 1'b0, 1'b1);
    wait_done(500, 4);

    // Length 1 and length 0 (treated as 1), under backpressure
    do_reset();
    run(1, 0, 2, 2, 0, 1'b1, 1'b0);
    wait_done(500, 6);
    chk("len0_ctrl", last_ctrl, 24'h001001);

    // High seed wrap: 240..255 then 0
    do_reset();
    run(4, 4, 0, 17, 0, 1'b0, 1'b0);
    wait_done(1000, 17);
    chk("wrap_last_seed", last_data, 8'h00);

    // Stop during beat 5 of an endless run
    do_reset();
    run(64, 64, 3, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 300 && mbeat != 4; i++) @(posedge clk_sys);
    if (mbeat != 4) fail_now("stop_beat_timeout");
    #1;
    stop = 1'b1;
    @(posedge clk_sys);
    #1;
    stop = 1'b0;
    wait_done(400, 1);

    // Config changes while busy have no effect
    do_reset();
    run(64, 8, 2, 1, 0, 1'b0, 1'b0);
    cfg_len_lo = 12'd16;
    wait_done(500, 3);
    chk("latch_first_ctrl", first_ctrl, 24'h040040);
    chk("latch_last_ctrl", last_ctrl, 24'h008008);

    // Reset mid-packet: outputs clear immediately (checked inside do_reset)
    do_reset();
    run(64, 64, 1, 1, 0, 1'b0, 1'b0);
    repeat (5) @(posedge clk_sys);
    #3;
    chk("pre_reset_valid", f_rec_data_valid, 1);
    do_reset();
    repeat (3) @(posedge clk_sys);
    #2;
    chk("post_reset_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
